// File: rtl/serial_bit_feeder.sv
// rtl/serial_bit_feeder.sv - parallel-to-serial feeder with one-word holding buffer
// Streams WIDTH-bit words onto ser_out one bit per clk, back-to-back when possible.
module serial_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_active,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] hold;
  logic [CW-1:0]    cnt;
  logic             hold_full;

  logic             accept;
  logic             eow;
  logic             load_hold;
  logic             load_in;
  logic             to_hold;
  logic [WIDTH-1:0] load_word;

  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign in_ready  = rstn & ~hold_full;
  assign busy      = (state == SHIFT) | hold_full;
  assign accept    = in_valid & in_ready;
  // eow: the last bit of the current word is on ser_out right now
  assign eow       = (state == SHIFT) && (cnt == LAST);
  assign load_hold = eow & hold_full;
  assign load_in   = accept & ((state == IDLE) | (eow & ~hold_full));
  assign to_hold   = accept & (state == SHIFT) & ~eow;
  assign load_word = load_hold ? hold : in_data;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      sreg       <= '0;
      hold       <= '0;
      cnt        <= '0;
      hold_full  <= 1'b0;
      ser_out    <= IDLE_BIT;
      ser_active <= 1'b0;
      word_done  <= 1'b0;
    end else begin
      if (to_hold) begin
        hold      <= in_data;
        hold_full <= 1'b1;
      end
      if (load_hold | load_in) begin
        // sreg keeps the bits still to come; the first one goes straight out
        state      <= SHIFT;
        ser_out    <= head(load_word);
        sreg       <= advance(load_word);
        cnt        <= '0;
        ser_active <= 1'b1;
        word_done  <= 1'b0;
        if (load_hold) hold_full <= 1'b0;
      end else if (state == SHIFT && !eow) begin
        ser_out   <= head(sreg);
        sreg      <= advance(sreg);
        cnt       <= cnt + 1'b1;
        word_done <= ((cnt + 1'b1) == LAST);
      end else if (state == SHIFT) begin
        state      <= IDLE;
        ser_out    <= IDLE_BIT;
        ser_active <= 1'b0;
        word_done  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb/tb_serial_bit_feeder.sv - directed self-checking bench for serial_bit_feeder
module tb_serial_bit_feeder;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] in_data, in_data1;
  logic       in_valid, in_valid1;
  logic       in_ready, ser_out, ser_active, word_done, busy;
  logic       in_ready1, ser_out1, ser_active1, word_done1, busy1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] cap;
  logic [63:0] dcap;
  int ncap;

  always #5 clk = ~clk;

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u0 (
    .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ser_out(ser_out), .ser_active(ser_active),
    .word_done(word_done), .busy(busy)
  );

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u1 (
    .clk(clk), .rstn(rstn), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .ser_out(ser_out1), .ser_active(ser_active1),
    .word_done(word_done1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // capture u0 stream for the cycle currently shown, then advance one clock
  task automatic tick();
    if (ser_active) begin
      cap  = {cap[62:0], ser_out};
      dcap = {dcap[62:0], word_done};
      ncap++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cap();
    cap = '0;
    dcap = '0;
    ncap = 0;
  endtask

  initial begin
    logic [7:0] seq;
    logic [7:0] words [3];
    int idx, n, k, ready_low;
    logic acc;

    rstn = 1'b0; in_valid = 1'b0; in_data = '0; in_valid1 = 1'b0; in_data1 = '0;
    clear_cap();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ser_out", ser_out, 0);
    check("rst_ser_active", ser_active, 0);
    check("rst_word_done", word_done, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    rstn = 1'b1;
    #1;
    check("rel_in_ready", in_ready, 1);

    // single word A8, MSB first
    tick();
    in_data = 8'hA8; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    seq = 8'b10101000;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t1_bit%0d", i), ser_out, seq[7-i]);
      check($sformatf("t1_done%0d", i), word_done, (i == 7));
      check($sformatf("t1_active%0d", i), ser_active, 1);
      tick();
    end
    check("t1_idle_out", ser_out, 0);
    check("t1_idle_active", ser_active, 0);
    check("t1_idle_busy", busy, 0);

    // back-to-back A5, 5A, FF with in_valid held high
    words[0] = 8'hA5; words[1] = 8'h5A; words[2] = 8'hFF;
    clear_cap();
    idx = 0; ready_low = 0;
    in_data = words[0]; in_valid = 1'b1;
    for (int c = 0; c < 40 && (in_valid || busy); c++) begin
      acc = in_valid & in_ready;
      if (!in_ready) ready_low++;
      tick();
      if (acc) begin
        idx++;
        if (idx < 3) in_data = words[idx];
        else in_valid = 1'b0;
      end
    end
    check("t2_all_accepted", idx, 3);
    check("t2_nbits", ncap, 24);
    check("t2_stream", cap[23:0], 24'hA55AFF);
    check("t2_done_mask", dcap[23:0], 24'h010101);
    check("t2_ready_dropped", (ready_low > 0), 1);

    // LSB first, word 15
    in_data1 = 8'h15; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    seq = '0; n = 0;
    for (int i = 0; i < 10; i++) begin
      if (ser_active1) begin
        seq = {seq[6:0], ser_out1};
        n++;
        if (n == 8) check("t3_done_last", word_done1, 1);
        else check($sformatf("t3_done%0d", n), word_done1, 0);
      end
      @(posedge clk); #1;
    end
    check("t3_bits", seq, 8'b10101000);
    check("t3_active_cycles", n, 8);

    // reset during bit 4 of FF with a word held
    in_data = 8'hFF; in_valid = 1'b1;
    tick();
    in_data = 8'h3C;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("t4_busy_before", busy, 1);
    check("t4_held", in_ready, 0);
    rstn = 1'b0;
    #1;
    check("t4_rst_out", ser_out, 0);
    check("t4_rst_active", ser_active, 0);
    check("t4_rst_busy", busy, 0);
    check("t4_rst_ready", in_ready, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    clear_cap();
    for (int i = 0; i < 12; i++) tick();
    check("t4_no_resume", ncap, 0);
    check("t4_idle_out", ser_out, 0);

    // new word exactly on end-of-word edge, buffer empty
    in_data = 8'hC3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    clear_cap();
    for (int i = 0; i < 7; i++) tick();
    check("t5_last_done", word_done, 1);
    in_data = 8'h81; in_valid = 1'b1;
    #1;
    check("t5_ready_eow", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("t5_no_gap", ser_active, 1);
    for (int i = 0; i < 12; i++) tick();
    check("t5_nbits", ncap, 16);
    check("t5_stream", cap[15:0], 16'hC381);

    // data churning while in_ready is low: only the accepted value is used
    clear_cap();
    in_data = 8'h0F; in_valid = 1'b1;
    tick();
    in_data = 8'hF0;
    tick();
    k = 0;
    while (!in_ready && k < 20) begin
      in_data = 8'($urandom);
      tick();
      k++;
    end
    check("t6_ready_back", in_ready, 1);
    in_data = 8'h96;
    tick();
    in_valid = 1'b0;
    in_data = 8'h00;
    k = 0;
    while (busy && k < 40) begin
      tick();
      k++;
    end
    check("t6_drained", busy, 0);
    check("t6_nbits", ncap, 24);
    check("t6_stream", cap[23:0], 24'h0FF096);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
